mod_pow2_scale: RTL and testbench
=================================

# mod_pow2_scale

Multi-cycle modular scaler computing out = in·2^s mod q, the inverse direction of the INTT halving stage: it multiplies by powers of two where that stage multiplies by 2^(-1). It performs one modular doubling per cycle. Valid/ready handshakes on both sides let it sit in the coefficient stream between a memory reader and the NTT datapath. It is used to undo accumulated 2^(-k) factors and to pre-scale operands.

## Interface
Parameters:
- LOGQ, 54, coefficient and modulus width in bits.
- SW, 6, width of the shift-amount port; s ranges over 0..2^SW−1.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operand present.
- in_ready  out  1  block accepts an operand this cycle.
- in  in  LOGQ  operand; caller guarantees in < q.
- s  in  SW  power of two to apply.
- q  in  LOGQ  odd modulus; caller guarantees q < 2^(LOGQ−1).
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  LOGQ  result, always < q.

## Operation
- States: IDLE, RUN, DONE. Registers: x (LOGQ), qr (LOGQ), cnt (SW).
- Accept: in_valid && in_ready. On the accepting edge, x←in, qr←q, cnt←s. Next state is DONE if s==0, otherwise RUN.
- RUN: each edge x←dbl(x), cnt←cnt−1. Transition to DONE on the edge where cnt==1.
- dbl(x): t = {x,1'b0}, computed at LOGQ+1 bits. Result is t−qr if t ≥ qr, else t. Invariant x < qr holds throughout.
- q, in and s are sampled only on the accepting edge. Later changes to them have no effect.
- DONE: out_valid=1 and out=x.
  - On out_ready && !in_valid, go to IDLE.
  - On out_ready && in_valid, the new operand is accepted on the same edge (back-to-back, no bubble).
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is combinational from state and out_ready.
- out_valid = (state==DONE). out is driven directly from x, with no output mux.
- Back-pressure: while DONE and !out_ready, x and out are held stable indefinitely.
- Reset (rst_n low, at any time including mid-RUN): state←IDLE, x←0, qr←0, cnt←0. The in-flight operand is discarded. No output handshake occurs for it.

## Timing
- Reset values: out_valid=0, out=0, in_ready=1 (state IDLE).
- Latency: out_valid rises on the s-th edge after the accepting edge; for s=0 it rises on the accepting edge itself. The result is visible s+1 cycles after the handshake cycle.
- Throughput: one result per s+1 cycles with out_ready held high.
- The critical path is one (LOGQ+1)-bit compare/subtract plus the mux. No pipelining inside the doubling loop.

## Structure
- Shared package entry: typedef enum logic [1:0] {IDLE, RUN, DONE} pow2_scale_state_t.
- Sub-module mod_double_step: purely combinational, LOGQ-parameterised, ports x and q in, y = 2x mod q out. It is reusable by other scaling blocks.
- Top level contains the FSM, counter, operand registers and handshake logic.

## Test plan
- q=17, in=5, s=3, out_ready=1 → out=6 (40 mod 17), out_valid on the 3rd edge after accept, asserted for exactly one cycle.
- q=97, in=96, s=1 → out=95. Exercises the subtract path at x=q−1.
- s=0, q=17, in=9 → out=9, out_valid one cycle after the handshake.
- LOGQ=54, q=2^53−111, in=q−1, s=53 → out=q−111. Compare 1000 random (in, s) pairs against a reference model.
- Hold out_ready=0 for 5 cycles in DONE → out and out_valid stable, in_ready=0. Then raise out_ready with in_valid=1 → result consumed and new operand accepted on the same edge.
- Assert rst_n=0 mid-RUN (q=17, in=5, s=10, after 4 cycles) → out_valid=0, out=0, in_ready=1 immediately. A fresh operand afterwards yields the correct result.

Source files
------------

// File: rtl/mod_pow2_scale_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_pow2_scale_pkg
// Description : Shared types and helpers for the power-of-two modular scaler.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_pow2_scale_pkg;

  // Default datapath widths: coefficient/modulus width and shift-port width.
  localparam int unsigned c_logq_default = 54;
  localparam int unsigned c_sw_default   = 6;

  // Scaler control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pow2_scale_state_t;

  // State entered on an accepting edge: a zero shift needs no doubling
  // and the operand is already the result.
  function automatic pow2_scale_state_t load_state(input logic s_is_zero);
    return s_is_zero ? DONE : RUN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_pow2_scale_double_step.sv
`default_nettype none
// ============================================================================
// Module      : mod_double_step
// Description : Combinational modular doubling, y = 2x mod q, for x < q.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_double_step
  import mod_pow2_scale_pkg::*;
#(
  parameter int LOGQ = c_logq_default
) (
  input  logic [LOGQ-1:0] x_i,
  input  logic [LOGQ-1:0] q_i,
  output logic [LOGQ-1:0] y_o
);

  logic [LOGQ:0] w_t;
  logic          w_ge;

  // 2x needs one extra bit; since x < q the reduced result is below q,
  // so the subtraction can be done at LOGQ bits and the carry dropped.
  assign w_t  = {x_i, 1'b0};
  assign w_ge = (w_t >= {1'b0, q_i});
  assign y_o  = w_ge ? (w_t[LOGQ-1:0] - q_i) : w_t[LOGQ-1:0];

endmodule
`default_nettype wire

// File: rtl/mod_pow2_scale.sv
`default_nettype none
// ============================================================================
// Module      : mod_pow2_scale
// Description : Multi-cycle scaler out = in * 2^s mod q, one modular doubling
//               per cycle, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_pow2_scale
  import mod_pow2_scale_pkg::*;
#(
  parameter int LOGQ = c_logq_default,
  parameter int SW   = c_sw_default
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [LOGQ-1:0] in_i,
  input  logic [SW-1:0]   s_i,
  input  logic [LOGQ-1:0] q_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [LOGQ-1:0] out_o
);

  localparam logic [SW-1:0] c_cnt_one  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] c_cnt_zero = '0;

  pow2_scale_state_t state_q, state_d;
  logic [LOGQ-1:0]   x_q, x_d;
  logic [LOGQ-1:0]   qr_q, qr_d;
  logic [SW-1:0]     cnt_q, cnt_d;

  logic [LOGQ-1:0]   w_dbl;
  logic              w_accept;

  mod_double_step #(
    .LOGQ (LOGQ)
  ) u_double_step (
    .x_i (x_q),
    .q_i (qr_q),
    .y_o (w_dbl)
  );

  // A new operand may enter when idle, or when the finished result is being
  // taken on this same edge (back-to-back without a bubble).
  assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign w_accept    = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign out_o       = x_q;

  // Next-state logic: load on accept, double while running, release on consume.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    qr_d    = qr_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        x_d   = w_dbl;
        cnt_d = cnt_q - c_cnt_one;
        if (cnt_q == c_cnt_one) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accepting overrides the consume-to-IDLE path so DONE can hand off
    // directly to the next operand.
    if (w_accept) begin
      x_d     = in_i;
      qr_d    = q_i;
      cnt_d   = s_i;
      state_d = load_state(s_i == c_cnt_zero);
    end
  end

  // State and operand registers; reset discards any in-flight operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      qr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      qr_q    <= qr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_pow2_scale.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_pow2_scale
// Description : Self-checking bench for mod_pow2_scale: directed cases plus
//               randomized operands against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_pow2_scale;

  localparam int LOGQ = 54;
  localparam int SW   = 6;
  localparam logic [LOGQ-1:0] Q53 = (54'd1 << 53) - 54'd111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [LOGQ-1:0] in_d = '0;
  logic [LOGQ-1:0] q_d = '0;
  logic [SW-1:0]   s_d = '0;
  wire             in_ready;
  wire             out_valid;
  wire [LOGQ-1:0]  out;

  int total = 0;
  int bad   = 0;

  // model state (owned by the compare process)
  bit              m_pend = 1'b0;
  int              m_rem  = 0;
  logic [LOGQ-1:0] m_res  = '0;
  bit              m_ev;
  bit              m_er;

  mod_pow2_scale #(
    .LOGQ (LOGQ),
    .SW   (SW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_i        (in_d),
    .s_i         (s_d),
    .q_i         (q_d),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_o       (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, in * 2^s reduced mod q.
  function automatic logic [LOGQ-1:0] model_scale(input logic [LOGQ-1:0] a,
                                                  input int unsigned sh,
                                                  input logic [LOGQ-1:0] m);
    logic [127:0] w;
    w = {74'd0, a} << sh;
    return LOGQ'(w % {74'd0, m});
  endfunction

  // Compare process: every negedge, check outputs against the model, then
  // advance the model using the inputs that the coming posedge will see.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pend = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out", out, 0);
      end else begin
        m_ev = m_pend && (m_rem == 0);
        m_er = !m_pend || (m_ev && out_ready);
        chk("out_valid", out_valid, m_ev);
        chk("in_ready", in_ready, m_er);
        if (m_ev) chk("out", out, m_res);
        if (m_pend && m_rem > 0) m_rem--;
        else if (m_ev && out_ready) m_pend = 1'b0;
        if (in_valid && m_er) begin
          m_pend = 1'b1;
          m_rem  = int'(s_d);
          m_res  = model_scale(in_d, s_d, q_d);
        end
      end
    end
  end

  // Drive an operand and return after its accepting edge (posedge+1 region).
  task automatic send(input logic [LOGQ-1:0] a, input logic [SW-1:0] sh,
                      input logic [LOGQ-1:0] m);
    int n;
    in_d = a; s_d = sh; q_d = m; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; lat counts edges after the accepting edge.
  task automatic wait_valid(output logic [LOGQ-1:0] got, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
    got = out;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [LOGQ-1:0] got;
    int lat;
    int acc;
    int cyc;

    // model pins
    chk("pin_model_17", model_scale(54'd5, 3, 54'd17), 6);
    chk("pin_model_97", model_scale(54'd96, 1, 54'd97), 95);
    chk("pin_model_s0", model_scale(54'd9, 0, 54'd17), 9);
    chk("pin_model_q53", model_scale(Q53 - 54'd1, 53, Q53), Q53 - 54'd111);

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    out_ready = 1'b1;

    // 5*8 mod 17, valid on 3rd edge, for exactly one cycle
    send(54'd5, 6'd3, 54'd17);
    wait_valid(got, lat);
    chk("t1_out", got, 6);
    chk("t1_lat", lat, 3);
    @(posedge clk); #1;
    chk("t1_one_cycle", out_valid, 0);

    // subtract path at x = q-1
    send(54'd96, 6'd1, 54'd97);
    wait_valid(got, lat);
    chk("t2_out", got, 95);
    chk("t2_lat", lat, 1);

    // s = 0 passes through, valid on the accepting edge
    send(54'd9, 6'd0, 54'd17);
    wait_valid(got, lat);
    chk("t3_out", got, 9);
    chk("t3_lat", lat, 0);

    // full-width case
    send(Q53 - 54'd1, 6'd53, Q53);
    wait_valid(got, lat);
    chk("t4_out", got, Q53 - 54'd111);
    chk("t4_lat", lat, 53);

    // back-pressure then back-to-back handoff
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(54'd7, 6'd4, 54'd17);
    wait_valid(got, lat);
    chk("bp_out", got, 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_out", out, 10);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    in_d = 54'd5; s_d = 6'd3; q_d = 54'd17;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_consumed", out_valid, 0);
    wait_valid(got, lat);
    chk("b2b_out", got, 6);
    chk("b2b_lat", lat, 3);

    // reset mid-RUN
    @(posedge clk); #1;
    send(54'd5, 6'd10, 54'd17);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(54'd9, 6'd2, 54'd17);
    wait_valid(got, lat);
    chk("post_rst_out", got, 2);
    chk("post_rst_lat", lat, 2);

    // randomized operands, handshakes and back-pressure
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 3) != 0;
      if (($urandom % 2) != 0) begin
        q_d = Q53;
      end else begin
        q_d = LOGQ'({$urandom, $urandom} & 64'h001F_FFFF_FFFF_FFFF) | 54'd1;
        if (q_d < 54'd3) q_d = 54'd3;
      end
      in_d = LOGQ'({$urandom, $urandom} % {10'd0, q_d});
      s_d  = (($urandom % 4) == 0) ? SW'($urandom_range(0, 63))
                                   : SW'($urandom_range(0, 7));
      if (in_valid && in_ready) acc++;
    end
    chk("random_accepts", acc, 1000);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("drain_idle", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
